// File: rtl/uart_rx_irq.sv
// 8N1 UART receiver with a small receive FIFO, memory-mapped RBR/STATUS/CTRL registers,
// and a one-shot irq1 request that re-arms on software ack or when the FIFO drains.
module uart_rx_irq #(
   parameter int          CLKS_PER_BIT = 868,
   parameter int          FIFO_DEPTH   = 8,
   parameter logic [63:0] BASE_ADDR    = 64'h1000_0000,
   parameter int          ADDR_W       = 64,
   parameter int          XLEN         = 64
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              rxd,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic              ren,
   input  logic              wen,
   input  logic [XLEN-1:0]   wdata,
   output logic [XLEN-1:0]   rdata,
   output logic              irq1
);

   localparam int                PTR_W    = $clog2(FIFO_DEPTH);
   localparam logic [15:0]       FULL_BIT = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0]       HALF_BIT = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [6:0]        DEPTH    = 7'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] RBR_A    = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] STAT_A   = ADDR_W'(BASE_ADDR + 64'd4);
   localparam logic [ADDR_W-1:0] CTRL_A   = ADDR_W'(BASE_ADDR + 64'd8);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

   rx_state_t        state;
   logic             rx_p0, rx_s;
   logic [15:0]      bit_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [6:0]       count;
   logic             frame_err, overrun, ie, armed;

   logic empty, full, sel_rbr, sel_stat, sel_ctrl, pop, ctrl_wr, ack, clr;
   logic byte_done, push, bad_stop, push_ok, fire, drained;
   logic unused_wdata;

   assign empty     = (count == 7'd0);
   assign full      = (count == DEPTH);
   assign sel_rbr   = (data_addr == RBR_A);
   assign sel_stat  = (data_addr == STAT_A);
   assign sel_ctrl  = (data_addr == CTRL_A);
   assign pop       = ren && sel_rbr && !empty;
   assign ctrl_wr   = wen && sel_ctrl;
   assign ack       = ctrl_wr && wdata[1];
   assign clr       = ctrl_wr && wdata[2];
   assign byte_done = (state == STOP) && (bit_cnt == 16'd0);
   assign push      = byte_done && rx_s;
   assign bad_stop  = byte_done && !rx_s;
   assign push_ok   = push && !full;
   assign fire      = ie && armed && !empty;
   // A pop that leaves the FIFO empty re-arms so the next byte interrupts again.
   assign drained   = pop && (count == 7'd1) && !push_ok;
   assign unused_wdata = ^wdata[XLEN-1:3];

   always_comb begin
      rdata = '0;
      if (sel_rbr && !empty)
         rdata = XLEN'(mem[rd_ptr]);
      else if (sel_stat)
         rdata = XLEN'({count, overrun, frame_err, full, empty});
      else if (sel_ctrl)
         rdata = XLEN'(ie);
   end

   // Two-flop synchroniser; idle level is high.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rx_p0 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         rx_p0 <= rxd;
         rx_s  <= rx_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state   <= IDLE;
         bit_cnt <= '0;
         bit_idx <= '0;
      end else begin
         case (state)
            IDLE: if (!rx_s) begin
               state   <= START;
               bit_cnt <= HALF_BIT;
            end
            START: if (bit_cnt == 16'd0) begin
               if (rx_s) begin
                  state <= IDLE;
               end else begin
                  state   <= DATA;
                  bit_cnt <= FULL_BIT;
                  bit_idx <= '0;
               end
            end else begin
               bit_cnt <= bit_cnt - 16'd1;
            end
            DATA: if (bit_cnt == 16'd0) begin
               bit_cnt <= FULL_BIT;
               bit_idx <= bit_idx + 3'd1;
               if (bit_idx == 3'd7) state <= STOP;
            end else begin
               bit_cnt <= bit_cnt - 16'd1;
            end
            STOP: if (bit_cnt == 16'd0) state <= IDLE;
                  else bit_cnt <= bit_cnt - 16'd1;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == DATA && bit_cnt == 16'd0) shift <= {rx_s, shift[7:1]};
      if (push_ok) mem[wr_ptr] <= shift;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + 7'(push_ok) - 7'(pop);
         if (clr) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
         end
         if (bad_stop)     frame_err <= 1'b1;
         if (push && full) overrun   <= 1'b1;
      end
   end

   // Ack takes priority over a coincident fire, pushing the pulse one cycle later.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         ie    <= 1'b0;
         armed <= 1'b1;
         irq1  <= 1'b0;
      end else begin
         if (ctrl_wr) ie <= wdata[0];
         irq1 <= fire && !ack;
         if (ack || drained) armed <= 1'b1;
         else if (fire)      armed <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_irq.sv
// Self-checking bench for uart_rx_irq: serial frames on rxd, bus reads/writes, and a
// queue-based model of FIFO contents, sticky flags and irq1 pulses.
module tb_uart_rx_irq;

   localparam int          CPB   = 16;
   localparam int          DEPTH = 8;
   localparam logic [63:0] BASE  = 64'h1000_0000;
   localparam logic [63:0] RBR   = BASE;
   localparam logic [63:0] STAT  = BASE + 64'd4;
   localparam logic [63:0] CTRL  = BASE + 64'd8;
   // rxd falling edge -> irq1: 2 sync flops + 1 detect, half bit, 8 data bits, stop bit, 1 irq register
   localparam int          IRQ_LAT = 3 + CPB / 2 + 9 * CPB + 1;

   logic        clk = 1'b0;
   logic        rstn, rxd, ren, wen;
   logic [63:0] data_addr, wdata, rdata;
   logic        irq1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int irq_cnt = 0, irq_wide = 0, irq_last = 0;
   logic irq_prev = 1'b0;

   logic [7:0] q[$];
   bit m_fe = 0, m_ov = 0;

   uart_rx_irq #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE),
                 .ADDR_W(64), .XLEN(64)) dut (
      .clk(clk), .rstn(rstn), .rxd(rxd), .data_addr(data_addr), .ren(ren),
      .wen(wen), .wdata(wdata), .rdata(rdata), .irq1(irq1));

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) begin
      if (irq1 === 1'b1) begin
         irq_cnt  = irq_cnt + 1;
         irq_last = cyc;
         if (irq_prev === 1'b1) irq_wide = irq_wide + 1;
      end
      irq_prev = irq1;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic logic [63:0] stat_exp();
      int n = q.size();
      logic [10:0] s;
      s = {7'(n), m_ov, m_fe, (n == DEPTH), (n == 0)};
      return 64'(s);
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_rd(input logic [63:0] a, output logic [63:0] d);
      data_addr = a;
      ren = 1'b1;
      @(negedge clk);
      d = rdata;
      @(posedge clk);
      #1;
      ren = 1'b0;
      data_addr = '0;
   endtask

   task automatic bus_wr(input logic [63:0] a, input logic [63:0] v);
      data_addr = a;
      wdata = v;
      wen = 1'b1;
      @(posedge clk);
      #1;
      wen = 1'b0;
      wdata = '0;
      data_addr = '0;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop, output int start_cyc);
      rxd = 1'b0;
      start_cyc = cyc;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         tick(CPB);
      end
      rxd = stop;
      tick(CPB);
      rxd = 1'b1;
      if (stop) begin
         if (q.size() < DEPTH) q.push_back(b);
         else m_ov = 1;
      end else begin
         m_fe = 1;
      end
      tick(stop ? 4 : 2 * CPB);
   endtask

   task automatic read_expect(input string name);
      logic [63:0] d, e;
      e = (q.size() > 0) ? 64'(q.pop_front()) : 64'd0;
      bus_rd(RBR, d);
      total++;
      if (d !== e) begin
         bad++;
         $display("FAIL %s rbr got=%h exp=%h", name, d, e);
      end
   endtask

   task automatic test_reset();
      logic [63:0] d;
      rstn = 1'b0; rxd = 1'b1; ren = 1'b0; wen = 1'b0; data_addr = '0; wdata = '0;
      tick(3);
      rstn = 1'b1;
      tick(1);
      total++;
      if (irq1 !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq1); end
      bus_rd(STAT, d);
      total++;
      if (d !== 64'h1) begin bad++; $display("FAIL reset_status got=%h exp=%h", d, 64'h1); end
      bus_rd(CTRL, d);
      total++;
      if (d !== 64'h0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", d); end
      read_expect("reset_rbr");
   endtask

   task automatic test_single();
      logic [63:0] d;
      int c0;
      bus_wr(CTRL, 64'h1);
      irq_cnt = 0; irq_wide = 0;
      send_frame(8'hA5, 1, c0);
      total++;
      if (irq_cnt !== 1) begin bad++; $display("FAIL single_irq_cnt got=%0d exp=1", irq_cnt); end
      total++;
      if (irq_last - c0 !== IRQ_LAT) begin
         bad++; $display("FAIL single_irq_lat got=%0d exp=%0d", irq_last - c0, IRQ_LAT);
      end
      total++;
      if (irq_wide !== 0) begin bad++; $display("FAIL single_irq_width got=%0d exp=0", irq_wide); end
      bus_rd(STAT, d);
      total++;
      if (d !== stat_exp()) begin bad++; $display("FAIL single_status got=%h exp=%h", d, stat_exp()); end
      read_expect("single");
      bus_rd(STAT, d);
      total++;
      if (d !== stat_exp()) begin bad++; $display("FAIL single_empty got=%h exp=%h", d, stat_exp()); end
   endtask

   task automatic test_three();
      int c0;
      bus_wr(CTRL, 64'h1);
      irq_cnt = 0; irq_wide = 0;
      send_frame(8'h11, 1, c0);
      send_frame(8'h22, 1, c0);
      send_frame(8'h33, 1, c0);
      total++;
      if (irq_cnt !== 1) begin bad++; $display("FAIL three_irq_cnt got=%0d exp=1", irq_cnt); end
      for (int i = 0; i < 3; i++) read_expect("three");
      send_frame(8'h44, 1, c0);
      total++;
      if (irq_cnt !== 2) begin bad++; $display("FAIL rearm_irq_cnt got=%0d exp=2", irq_cnt); end
      read_expect("rearm");
   endtask

   task automatic test_overrun();
      logic [63:0] d;
      int c0;
      bus_wr(CTRL, 64'h0);
      irq_cnt = 0;
      for (int i = 0; i < DEPTH + 1; i++) send_frame(8'($urandom), 1, c0);
      bus_rd(STAT, d);
      total++;
      if (d !== stat_exp() || d !== 64'h8A) begin
         bad++; $display("FAIL overrun_status got=%h exp=%h", d, stat_exp());
      end
      for (int i = 0; i < DEPTH; i++) read_expect("overrun");
      bus_wr(CTRL, 64'h4);
      m_ov = 0;
      bus_rd(STAT, d);
      total++;
      if (d !== stat_exp()) begin bad++; $display("FAIL overrun_clear got=%h exp=%h", d, stat_exp()); end
      total++;
      if (irq_cnt !== 0) begin bad++; $display("FAIL overrun_irq got=%0d exp=0", irq_cnt); end
   endtask

   task automatic test_frame_err();
      logic [63:0] d;
      int c0;
      bus_wr(CTRL, 64'h1);
      irq_cnt = 0;
      send_frame(8'h5A, 0, c0);
      bus_rd(STAT, d);
      total++;
      if (d !== stat_exp()) begin bad++; $display("FAIL ferr_status got=%h exp=%h", d, stat_exp()); end
      total++;
      if (irq_cnt !== 0) begin bad++; $display("FAIL ferr_irq got=%0d exp=0", irq_cnt); end
      send_frame(8'h3C, 1, c0);
      total++;
      if (irq_cnt !== 1) begin bad++; $display("FAIL ferr_next_irq got=%0d exp=1", irq_cnt); end
      read_expect("ferr_next");
      bus_wr(CTRL, 64'h5);
      m_fe = 0;
      bus_rd(STAT, d);
      total++;
      if (d !== stat_exp()) begin bad++; $display("FAIL ferr_clear got=%h exp=%h", d, stat_exp()); end
   endtask

   task automatic test_glitch();
      logic [63:0] d;
      irq_cnt = 0;
      rxd = 1'b0;
      tick(CPB / 4);
      rxd = 1'b1;
      tick(2 * CPB);
      bus_rd(STAT, d);
      total++;
      if (d !== stat_exp()) begin bad++; $display("FAIL glitch_status got=%h exp=%h", d, stat_exp()); end
      total++;
      if (irq_cnt !== 0) begin bad++; $display("FAIL glitch_irq got=%0d exp=0", irq_cnt); end
   endtask

   task automatic test_random();
      logic [63:0] d;
      int c0;
      bus_wr(CTRL, 64'h4);
      m_fe = 0; m_ov = 0;
      for (int it = 0; it < 10; it++) begin
         send_frame(8'($urandom), ($urandom_range(0, 3) != 0), c0);
         for (int r = 0; r < int'($urandom_range(0, 2)); r++) read_expect("random");
         bus_rd(STAT, d);
         total++;
         if (d !== stat_exp()) begin bad++; $display("FAIL random_status got=%h exp=%h", d, stat_exp()); end
      end
      while (q.size() > 0) read_expect("random_drain");
      bus_wr(CTRL, 64'h4);
      m_fe = 0; m_ov = 0;
   endtask

   task automatic test_ie_enable();
      int c0;
      bus_wr(CTRL, 64'h0);
      irq_cnt = 0;
      send_frame(8'($urandom), 1, c0);
      send_frame(8'($urandom), 1, c0);
      total++;
      if (irq_cnt !== 0) begin bad++; $display("FAIL ie0_irq got=%0d exp=0", irq_cnt); end
      bus_wr(CTRL, 64'h1);
      tick(1);
      total++;
      if (irq1 !== 1'b1) begin bad++; $display("FAIL ie_set_irq got=%b exp=1", irq1); end
      tick(2);
      bus_wr(CTRL, 64'h3);
      total++;
      if (irq1 !== 1'b0) begin bad++; $display("FAIL ack_cycle_irq got=%b exp=0", irq1); end
      tick(1);
      total++;
      if (irq1 !== 1'b1) begin bad++; $display("FAIL ack_rearm_irq got=%b exp=1", irq1); end
      tick(1);
      total++;
      if (irq_cnt !== 2) begin bad++; $display("FAIL ie_irq_cnt got=%0d exp=2", irq_cnt); end
      read_expect("ie_read");
   endtask

   task automatic test_reset_mid();
      logic [63:0] d;
      int c0;
      rxd = 1'b0;
      tick(3 * CPB);
      rstn = 1'b0;
      tick(1);
      rxd = 1'b1;
      total++;
      if (irq1 !== 1'b0) begin bad++; $display("FAIL rstmid_irq got=%b exp=0", irq1); end
      q.delete();
      m_fe = 0; m_ov = 0;
      bus_rd(STAT, d);
      total++;
      if (d !== 64'h1) begin bad++; $display("FAIL rstmid_status got=%h exp=%h", d, 64'h1); end
      bus_rd(CTRL, d);
      total++;
      if (d !== 64'h0) begin bad++; $display("FAIL rstmid_ctrl got=%h exp=0", d); end
      tick(2);
      rstn = 1'b1;
      tick(2);
      read_expect("rstmid_rbr");
      bus_wr(CTRL, 64'h1);
      irq_cnt = 0;
      send_frame(8'($urandom), 1, c0);
      total++;
      if (irq_cnt !== 1) begin bad++; $display("FAIL rstmid_irq_cnt got=%0d exp=1", irq_cnt); end
      read_expect("rstmid_frame");
   endtask

   initial begin
      test_reset();
      test_single();
      test_three();
      test_overrun();
      test_frame_err();
      test_glitch();
      test_random();
      test_ie_enable();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
